// File: rtl/jpeg_cone_eval_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_cone_eval_arbiter_if
// Description : Bundles the request, cone and response signals of the shared
//               JPEG cone arbiter. The slave modport is the arbiter; the master
//               modport is its environment (clients, cone and consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface jpeg_cone_eval_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 6,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_vec;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      cone_in;
  logic              cone_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_data;
  logic              busy;

  modport slave (
    input  req_valid, req_vec, cone_out, rsp_ready,
    output req_ready, cone_in, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_vec, cone_out, rsp_ready,
    input  req_ready, cone_in, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_cone_eval_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_cone_eval_arbiter
// Description : Round-robin arbiter sharing one combinational cone among NREQ
//               requesters. Accepted vectors are launched into a registered
//               cone input, the cone output is captured LAT cycles later and
//               returned in issue order through a credit-limited FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_cone_eval_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 6,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  jpeg_cone_eval_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  // Registered state
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   cone_in_q, cone_in_d;
  logic [LAT:1]   vld_q, vld_d;
  logic [IDW-1:0] sid_q [1:LAT];
  logic [IDW-1:0] sid_d [1:LAT];
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDW:0]   mem_q [DEPTH];
  logic [IDW:0]   mem_d [DEPTH];

  // Combinational terms
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    win_vec;
  logic            found;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;

  // Credit check uses registered counts only, so rsp_ready never reaches req_ready.
  assign credit_ok = (inflight_q + fifo_cnt_q) < CW'(DEPTH);
  assign push      = vld_q[LAT];
  assign pop       = bus.rsp_valid & bus.rsp_ready;

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin : p_arb
    int j;
    j       = 0;
    grant   = '0;
    win_id  = '0;
    win_vec = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win_id   = IDW'(j);
        win_vec  = bus.req_vec[j*W +: W];
      end
    end
  end

  // Grant is suppressed while in reset and while no credit remains.
  assign bus.req_ready = (rst_n && credit_ok) ? grant : '0;
  assign accept        = |bus.req_ready;

  // Next-state logic for pointer, launch register, pipeline and FIFO.
  always_comb begin : p_next
    ptr_d      = ptr_q;
    cone_in_d  = cone_in_q;
    vld_d      = '0;
    inflight_d = inflight_q + CW'(accept) - CW'(push);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    for (int k = 1; k <= LAT; k++) sid_d[k] = sid_q[k];
    for (int k = 0; k < DEPTH; k++) mem_d[k] = mem_q[k];

    if (accept) begin
      ptr_d     = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
      cone_in_d = win_vec;
    end

    vld_d[1] = accept;
    sid_d[1] = win_id;
    for (int k = 2; k <= LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      sid_d[k] = sid_q[k-1];
    end

    if (push) mem_d[wr_ptr_q] = {sid_q[LAT], bus.cone_out};
  end

  // State registers; reset drops everything in flight or buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      cone_in_q  <= '0;
      vld_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int k = 1; k <= LAT; k++) sid_q[k] <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cone_in_q  <= cone_in_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int k = 1; k <= LAT; k++) sid_q[k] <= sid_d[k];
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
    end
  end

  assign bus.cone_in   = cone_in_q;
  assign bus.rsp_valid = (fifo_cnt_q != '0);
  assign bus.rsp_id    = mem_q[rd_ptr_q][IDW:1];
  assign bus.rsp_data  = mem_q[rd_ptr_q][0];
  assign bus.busy      = (inflight_q != '0) | (fifo_cnt_q != '0);

  // A push into a full FIFO means the credit accounting is broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt_q == CW'(DEPTH))));

endmodule
`default_nettype wire
